// File: rtl/data_stack.sv
// Parametrised LIFO data stack with top/NOS registers, depth tracking and sticky error flags.
// Optional high-water-mark output o_hwm is built when DATA_STACK_HWM_EN is defined.
module data_stack #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_clr_err,
  output logic [WIDTH-1:0] o_top,
  output logic [WIDTH-1:0] o_next,
  output logic [CW-1:0]    o_depth,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_ovf,
  output logic             o_unf
`ifdef DATA_STACK_HWM_EN
  ,
  output logic [CW-1:0]    o_hwm
`endif
);

  localparam int AW = (DEPTH > 4) ? $clog2(DEPTH - 2) : 1;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_PUSH    = 3'd1,
    OP_POP     = 3'd2,
    OP_REPLACE = 3'd3,
    OP_DUP     = 3'd4,
    OP_SWAP    = 3'd5,
    OP_OVER    = 3'd6,
    OP_CLEAR   = 3'd7
  } op_e;

  logic [WIDTH-1:0] top_q, top_d, next_q, next_d;
  logic [CW-1:0]    depth_q, depth_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic [WIDTH-1:0] arr_q [0:DEPTH-3];

  logic             full_s, empty_s, lt2_s;
  logic             push_s, arr_we_s, err_ovf_s, err_unf_s;
  logic [WIDTH-1:0] push_val_s;
  logic [AW-1:0]    wr_idx_s, rd_idx_s;

  assign full_s   = (depth_q == CW'(DEPTH));
  assign empty_s  = (depth_q == {CW{1'b0}});
  assign lt2_s    = (depth_q < CW'(2));
  // NOS spills to the slot just above the current array contents; POP refills from the slot below.
  assign wr_idx_s = AW'(depth_q - CW'(2));
  assign rd_idx_s = AW'(depth_q - CW'(3));

  // Next-state decode for one stack op; illegal ops only raise a flag.
  always_comb begin
    top_d      = top_q;
    next_d     = next_q;
    depth_d    = depth_q;
    push_s     = 1'b0;
    push_val_s = i_data;
    arr_we_s   = 1'b0;
    err_ovf_s  = 1'b0;
    err_unf_s  = 1'b0;
    case (op_e'(i_op))
      OP_PUSH: begin
        if (full_s) err_ovf_s = 1'b1;
        else        push_s    = 1'b1;
      end
      OP_POP: begin
        if (empty_s) begin
          err_unf_s = 1'b1;
        end else begin
          top_d   = next_q;
          next_d  = (depth_q >= CW'(3)) ? arr_q[rd_idx_s] : {WIDTH{1'b0}};
          depth_d = depth_q - CW'(1);
        end
      end
      OP_REPLACE: begin
        if (empty_s) err_unf_s = 1'b1;
        else         top_d     = i_data;
      end
      OP_DUP: begin
        push_val_s = top_q;
        if (full_s)       err_ovf_s = 1'b1;
        else if (empty_s) err_unf_s = 1'b1;
        else              push_s    = 1'b1;
      end
      OP_SWAP: begin
        if (lt2_s) begin
          err_unf_s = 1'b1;
        end else begin
          top_d  = next_q;
          next_d = top_q;
        end
      end
      OP_OVER: begin
        push_val_s = next_q;
        if (full_s)     err_ovf_s = 1'b1;
        else if (lt2_s) err_unf_s = 1'b1;
        else            push_s    = 1'b1;
      end
      OP_CLEAR: begin
        top_d   = {WIDTH{1'b0}};
        next_d  = {WIDTH{1'b0}};
        depth_d = {CW{1'b0}};
      end
      default: begin
        top_d = top_q;
      end
    endcase
    if (push_s) begin
      arr_we_s = (depth_q >= CW'(2));
      next_d   = top_q;
      top_d    = push_val_s;
      depth_d  = depth_q + CW'(1);
    end else begin
      arr_we_s = 1'b0;
    end
    // A fresh error in the same cycle as a clear request keeps its flag set.
    ovf_d = err_ovf_s ? 1'b1 : (i_clr_err ? 1'b0 : ovf_q);
    unf_d = err_unf_s ? 1'b1 : (i_clr_err ? 1'b0 : unf_q);
  end

  // Top, NOS, depth and flag registers.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      top_q   <= {WIDTH{1'b0}};
      next_q  <= {WIDTH{1'b0}};
      depth_q <= {CW{1'b0}};
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      next_q  <= next_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Deep-entry storage; unreset because entries at or above depth are never observed.
  always_ff @(posedge i_clock) begin
    if (arr_we_s) arr_q[wr_idx_s] <= next_q;
  end

`ifdef DATA_STACK_HWM_EN
  logic [CW-1:0] hwm_q, hwm_d;

  // Track the deepest depth reached since reset.
  always_comb begin
    if (depth_d > hwm_q) hwm_d = depth_d;
    else                 hwm_d = hwm_q;
  end

  // High-water-mark register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) hwm_q <= {CW{1'b0}};
    else            hwm_q <= hwm_d;
  end

  assign o_hwm = hwm_q;
`endif

  assign o_top   = top_q;
  assign o_next  = next_q;
  assign o_depth = depth_q;
  assign o_empty = empty_s;
  assign o_full  = full_s;
  assign o_ovf   = ovf_q;
  assign o_unf   = unf_q;

endmodule

// File: tb/tb_data_stack.sv
// Self-checking bench for data_stack (WIDTH=16, DEPTH=4): directed steps plus a short random run,
// scored against a queue-based reference stack. Checks o_hwm when DATA_STACK_HWM_EN is defined.
module tb_data_stack;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int CW = 3;

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, REPL = 3'd3,
                         DUP = 3'd4, SWAP = 3'd5, OVER = 3'd6, CLR = 3'd7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    op;
  logic [W-1:0]  data;
  logic          clr;
  logic [W-1:0]  o_top, o_next;
  logic [CW-1:0] o_depth;
  logic          o_empty, o_full, o_ovf, o_unf;
`ifdef DATA_STACK_HWM_EN
  logic [CW-1:0] o_hwm;
`endif

  always #5 clk = ~clk;

  data_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_op(op), .i_data(data), .i_clr_err(clr),
    .o_top(o_top), .o_next(o_next), .o_depth(o_depth), .o_empty(o_empty),
    .o_full(o_full), .o_ovf(o_ovf), .o_unf(o_unf)
`ifdef DATA_STACK_HWM_EN
    , .o_hwm(o_hwm)
`endif
  );

  typedef struct packed {
    logic [W-1:0]  top;
    logic [W-1:0]  nxt;
    logic [CW-1:0] depth;
    logic          empty;
    logic          full;
    logic          ovf;
    logic          unf;
    logic [CW-1:0] hwm;
  } exp_t;

  exp_t         sb[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           n_step  = 0;
  logic [W-1:0] m_stk[$];
  logic         m_ovf = 1'b0, m_unf = 1'b0;
  int           m_hwm = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [2:0] mop, input logic [W-1:0] mdata, input logic mclr);
    int   d;
    logic eo, eu;
    logic [W-1:0] t;
    d  = m_stk.size();
    eo = 1'b0;
    eu = 1'b0;
    case (mop)
      PUSH: if (d < D) m_stk.push_back(mdata); else eo = 1'b1;
      POP:  if (d >= 1) t = m_stk.pop_back(); else eu = 1'b1;
      REPL: if (d >= 1) m_stk[d-1] = mdata; else eu = 1'b1;
      DUP:  if (d == D) eo = 1'b1; else if (d == 0) eu = 1'b1; else m_stk.push_back(m_stk[d-1]);
      SWAP: if (d >= 2) begin t = m_stk[d-1]; m_stk[d-1] = m_stk[d-2]; m_stk[d-2] = t; end
            else eu = 1'b1;
      OVER: if (d == D) eo = 1'b1; else if (d < 2) eu = 1'b1; else m_stk.push_back(m_stk[d-2]);
      CLR:  m_stk.delete();
      default: ;
    endcase
    if (mclr) begin m_ovf = 1'b0; m_unf = 1'b0; end
    if (eo) m_ovf = 1'b1;
    if (eu) m_unf = 1'b1;
    if (m_stk.size() > m_hwm) m_hwm = m_stk.size();
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    int   d;
    d       = m_stk.size();
    e.top   = (d >= 1) ? m_stk[d-1] : 16'h0000;
    e.nxt   = (d >= 2) ? m_stk[d-2] : 16'h0000;
    e.depth = CW'(d);
    e.empty = (d == 0);
    e.full  = (d == D);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    e.hwm   = CW'(m_hwm);
    return e;
  endfunction

  task automatic step(input logic [2:0] sop, input logic [W-1:0] sdata, input logic sclr);
    exp_t  e;
    string s;
    @(negedge clk);
    op = sop; data = sdata; clr = sclr;
    model(sop, sdata, sclr);
    sb.push_back(model_exp());
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_step++;
    s = $sformatf("s%0d_op%0d", n_step, sop);
    chk({s, "_top"},   32'(o_top),   32'(e.top));
    chk({s, "_next"},  32'(o_next),  32'(e.nxt));
    chk({s, "_depth"}, 32'(o_depth), 32'(e.depth));
    chk({s, "_empty"}, 32'(o_empty), 32'(e.empty));
    chk({s, "_full"},  32'(o_full),  32'(e.full));
    chk({s, "_ovf"},   32'(o_ovf),   32'(e.ovf));
    chk({s, "_unf"},   32'(o_unf),   32'(e.unf));
`ifdef DATA_STACK_HWM_EN
    chk({s, "_hwm"},   32'(o_hwm),   32'(e.hwm));
`endif
    op = NOP; clr = 1'b0;
  endtask

  initial begin
    logic [2:0] rop;
    rst_n = 1'b0; op = NOP; data = 16'h0000; clr = 1'b0;
    #12;
    chk("rst_top", 32'(o_top), 32'h0);
    chk("rst_depth", 32'(o_depth), 32'h0);
    chk("rst_empty", 32'(o_empty), 32'h1);
    chk("rst_flags", 32'({o_ovf, o_unf}), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // 1: three pushes
    step(PUSH, 16'h1111, 1'b0);
    step(PUSH, 16'h2222, 1'b0);
    step(PUSH, 16'h3333, 1'b0);
    chk("t1_top", 32'(o_top), 32'h3333);
    chk("t1_next", 32'(o_next), 32'h2222);
    chk("t1_depth", 32'(o_depth), 32'h3);
    // 2: fill, overflow, drain
    step(PUSH, 16'h4444, 1'b0);
    chk("t2_full", 32'(o_full), 32'h1);
    step(PUSH, 16'h5555, 1'b0);
    chk("t2_ovf", 32'(o_ovf), 32'h1);
    chk("t2_top_kept", 32'(o_top), 32'h4444);
    step(POP, 16'h0000, 1'b0);
    chk("t2_pop1", 32'(o_top), 32'h3333);
    step(POP, 16'h0000, 1'b0);
    step(POP, 16'h0000, 1'b0);
    chk("t2_pop3", 32'(o_top), 32'h1111);
    chk("t2_next_d1", 32'(o_next), 32'h0);
    step(POP, 16'h0000, 1'b0);
    chk("t2_empty", 32'(o_empty), 32'h1);
    // 3: underflow, clear races
    step(POP, 16'h0000, 1'b0);
    chk("t3_unf", 32'(o_unf), 32'h1);
    step(POP, 16'h0000, 1'b1);
    chk("t3_unf_wins", 32'(o_unf), 32'h1);
    step(NOP, 16'h0000, 1'b1);
    chk("t3_cleared", 32'({o_ovf, o_unf}), 32'h0);
    // 4: swap/over/dup
    step(PUSH, 16'h000A, 1'b0);
    step(PUSH, 16'h000B, 1'b0);
    step(SWAP, 16'h0000, 1'b0);
    chk("t4_swap", 32'({o_top, o_next}), 32'h000A_000B);
    step(OVER, 16'h0000, 1'b0);
    chk("t4_over", 32'({o_top, 13'd0, o_depth}), 32'h000B_0003);
    step(DUP, 16'h0000, 1'b0);
    chk("t4_dup", 32'({o_top, 13'd0, o_depth}), 32'h000B_0004);
    // 5: replace at depth 2, then CLEAR keeps flags
    step(CLR, 16'h0000, 1'b0);
    step(PUSH, 16'h0001, 1'b0);
    step(PUSH, 16'h0002, 1'b0);
    step(REPL, 16'hBEEF, 1'b0);
    chk("t5_repl", 32'({o_top, 13'd0, o_depth}), 32'hBEEF_0002);
    step(SWAP, 16'h0000, 1'b0);
    step(OVER, 16'h0000, 1'b0);
    step(DUP, 16'h0000, 1'b0);
    step(OVER, 16'h0000, 1'b0);
    step(CLR, 16'h0000, 1'b0);
    chk("t5_clr_flags", 32'({o_ovf, o_empty}), 32'h3);
    // Illegal ops on shallow stacks
    step(SWAP, 16'h0000, 1'b1);
    step(REPL, 16'h1234, 1'b0);
    step(DUP, 16'h0000, 1'b0);
    step(PUSH, 16'h0099, 1'b0);
    step(OVER, 16'h0000, 1'b0);
    step(SWAP, 16'h0000, 1'b0);

    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      if (rop == CLR && ($urandom_range(0, 3) != 0)) rop = PUSH;
      step(rop, 16'($urandom), ($urandom_range(0, 9) == 0));
    end
    step(PUSH, 16'h1234, 1'b0);

    // 6: async reset in the middle of a PUSH
    @(negedge clk);
    op = PUSH; data = 16'h7777;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_top", 32'(o_top), 32'h0);
    chk("rst_async_next", 32'(o_next), 32'h0);
    chk("rst_async_depth", 32'(o_depth), 32'h0);
    chk("rst_async_flags", 32'({o_ovf, o_unf}), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_abort_depth", 32'(o_depth), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; op = NOP;
    m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_hwm = 0;
    step(PUSH, 16'h0042, 1'b0);
    step(PUSH, 16'h0043, 1'b0);
    step(PUSH, 16'h0044, 1'b0);
    step(POP, 16'h0000, 1'b0);
    step(POP, 16'h0000, 1'b0);
    step(CLR, 16'h0000, 1'b0);
`ifdef DATA_STACK_HWM_EN
    chk("t6_hwm", 32'(o_hwm), 32'h3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
